// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM control-path pipeline registers.
package arm_pipe_pkg;

  localparam int REG_ADDR_W = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] ra1;
    logic [REG_ADDR_W-1:0] ra2;
    logic [REG_ADDR_W-1:0] wa;
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_write;
    logic                  branch;
  } ctrl_stage_t;

  localparam ctrl_stage_t CTRL_BUBBLE = '0;

  // A slot whose condition failed keeps its addresses and load flag but can
  // no longer write, retire or branch.
  function automatic ctrl_stage_t cond_gate(input ctrl_stage_t s, input logic cond);
    ctrl_stage_t g;
    g           = s;
    g.valid     = s.valid & cond;
    g.reg_write = s.reg_write & cond;
    g.mem_write = s.mem_write & cond;
    g.branch    = s.branch & cond;
    return g;
  endfunction

endpackage

// File: rtl/arm_pipelined_ctrl_stage_reg.sv
// One pipeline stage of control fields: async reset, synchronous flush to bubble.
module arm_pipelined_ctrl_stage_reg
  import arm_pipe_pkg::*;
#(
  parameter ctrl_stage_t RESET_VAL = CTRL_BUBBLE
) (
  input  logic        i_CLK,
  input  logic        i_RESET,
  input  logic        i_Flush,
  input  ctrl_stage_t i_D,
  output ctrl_stage_t o_Q
);

  ctrl_stage_t r_q;

  // Stage flop: reset wins, then flush inserts a bubble, otherwise load
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      r_q <= RESET_VAL;
    end else if (i_Flush) begin
      r_q <= CTRL_BUBBLE;
    end else begin
      r_q <= i_D;
    end
  end

  assign o_Q = r_q;

endmodule

// File: rtl/arm_pipelined_hazard_ctrl_pipe.sv
// Control-path pipeline D->E->M->W for the pipelined ARM core. Supplies the
// hazard unit with E/M/W addresses and enables, applies the E-stage condition
// result to side effects, and counts retired instructions and W bubbles.
module arm_pipelined_hazard_ctrl_pipe
  import arm_pipe_pkg::*;
#(
  parameter int CntWidth = 32
) (
  input  logic                  i_CLK,
  input  logic                  i_RESET,
  input  logic [REG_ADDR_W-1:0] i_RA_1D,
  input  logic [REG_ADDR_W-1:0] i_RA_2D,
  input  logic [REG_ADDR_W-1:0] i_WA_D,
  input  logic                  i_Valid_D,
  input  logic                  i_RegWrite_D,
  input  logic                  i_MemToReg_D,
  input  logic                  i_MemWrite_D,
  input  logic                  i_Branch_D,
  input  logic                  i_CondEx_E,
  input  logic                  i_Flush_Execute,
  input  logic                  i_Cnt_Clear,
  output logic [REG_ADDR_W-1:0] o_RegFile_RA_1E,
  output logic [REG_ADDR_W-1:0] o_RegFile_RA_2E,
  output logic [REG_ADDR_W-1:0] o_RegFile_WA_M,
  output logic [REG_ADDR_W-1:0] o_RegFile_WA_W,
  output logic                  o_Reg_Write_Memory,
  output logic                  o_Reg_Write_WriteBack,
  output logic                  o_Mem_To_Reg_Execute,
  output logic                  o_Mem_To_Reg_WriteBack,
  output logic                  o_Mem_Write_Memory,
  output logic                  o_Branch_Taken_E,
  output logic [CntWidth-1:0]   o_Retired_Count,
  output logic [CntWidth-1:0]   o_Bubble_Count
);

  localparam logic [CntWidth-1:0] CNT_ONE = {{(CntWidth-1){1'b0}}, 1'b1};

  ctrl_stage_t w_e_d;
  ctrl_stage_t w_e_q;
  ctrl_stage_t w_m_d;
  ctrl_stage_t w_m_q;
  ctrl_stage_t w_w_q;

  logic [CntWidth-1:0] r_retired_cnt;
  logic [CntWidth-1:0] r_bubble_cnt;

  // Assemble the D-stage slot; side-effect bits only count for a real instruction
  always_comb begin
    w_e_d            = CTRL_BUBBLE;
    w_e_d.ra1        = i_RA_1D;
    w_e_d.ra2        = i_RA_2D;
    w_e_d.wa         = i_WA_D;
    w_e_d.valid      = i_Valid_D;
    w_e_d.reg_write  = i_RegWrite_D & i_Valid_D;
    w_e_d.mem_to_reg = i_MemToReg_D & i_Valid_D;
    w_e_d.mem_write  = i_MemWrite_D & i_Valid_D;
    w_e_d.branch     = i_Branch_D & i_Valid_D;
  end

  // E stage: the hazard unit's flush replaces the incoming slot with a bubble
  arm_pipelined_ctrl_stage_reg u_stage_e (
    .i_CLK   (i_CLK),
    .i_RESET (i_RESET),
    .i_Flush (i_Flush_Execute),
    .i_D     (w_e_d),
    .o_Q     (w_e_q)
  );

  // The condition result is only known in E, so it is folded in on the way to M
  always_comb begin
    w_m_d = cond_gate(w_e_q, i_CondEx_E);
  end

  // M stage: never stalled or flushed
  arm_pipelined_ctrl_stage_reg u_stage_m (
    .i_CLK   (i_CLK),
    .i_RESET (i_RESET),
    .i_Flush (1'b0),
    .i_D     (w_m_d),
    .o_Q     (w_m_q)
  );

  // W stage: straight copy of M
  arm_pipelined_ctrl_stage_reg u_stage_w (
    .i_CLK   (i_CLK),
    .i_RESET (i_RESET),
    .i_Flush (1'b0),
    .i_D     (w_m_q),
    .o_Q     (w_w_q)
  );

  // Performance counters: a valid W slot retires, anything else is a bubble; clear wins
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      r_retired_cnt <= '0;
      r_bubble_cnt  <= '0;
    end else if (i_Cnt_Clear) begin
      r_retired_cnt <= '0;
      r_bubble_cnt  <= '0;
    end else if (w_w_q.valid) begin
      r_retired_cnt <= r_retired_cnt + CNT_ONE;
    end else begin
      r_bubble_cnt  <= r_bubble_cnt + CNT_ONE;
    end
  end

  assign o_RegFile_RA_1E        = w_e_q.ra1;
  assign o_RegFile_RA_2E        = w_e_q.ra2;
  assign o_Mem_To_Reg_Execute   = w_e_q.mem_to_reg;
  assign o_RegFile_WA_M         = w_m_q.wa;
  assign o_Reg_Write_Memory     = w_m_q.reg_write;
  assign o_Mem_Write_Memory     = w_m_q.mem_write;
  assign o_RegFile_WA_W         = w_w_q.wa;
  assign o_Reg_Write_WriteBack  = w_w_q.reg_write;
  assign o_Mem_To_Reg_WriteBack = w_w_q.mem_to_reg;
  assign o_Retired_Count        = r_retired_cnt;
  assign o_Bubble_Count         = r_bubble_cnt;

  // Branch resolves in E: the condition input is live, so this path is combinational
  assign o_Branch_Taken_E = w_e_q.branch & w_e_q.valid & i_CondEx_E;

endmodule
